// File: rtl/ultrasonic_pkg.sv
// Shared types and 50 MHz timing defaults for the ultrasonic ranging blocks.
package ultrasonic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_ECHO,
    ECHO_HI,
    HOLDOFF
  } state_t;

  localparam int TRIG_CYCLES_DEF    = 500;
  localparam int ECHO_TIMEOUT_DEF   = 1_500_000;
  localparam int HOLDOFF_CYCLES_DEF = 3_000_000;
  localparam int CNT_W_DEF          = 21;

  function automatic int bits_for(input int v);
    return (v <= 1) ? 1 : $clog2(v + 1);
  endfunction

  // The shared counter also holds the hold-off load, which can exceed CNT_W.
  function automatic int cnt_width(input int w, input int a, input int b, input int c);
    int r;
    r = w;
    if (bits_for(a) > r) r = bits_for(a);
    if (bits_for(b) > r) r = bits_for(b);
    if (bits_for(c) > r) r = bits_for(c);
    return r;
  endfunction

endpackage

// File: rtl/ultrasonic_trigger_ctrl_if.sv
// Sensor-side and result signals of the ultrasonic trigger controller.
interface ultrasonic_trigger_ctrl_if
  import ultrasonic_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) ();

  logic             start;
  logic             echo;
  logic             trig;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] echo_width;

  modport master (
    output start, echo,
    input  trig, busy, done, timeout, echo_width
  );

  modport slave (
    input  start, echo,
    output trig, busy, done, timeout, echo_width
  );

endinterface

// File: rtl/echo_sync.sv
// Two-flop synchroniser for the echo pin with rise/fall pulses; both edges see the same delay.
module echo_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

endmodule

// File: rtl/ultrasonic_trigger_ctrl.sv
// HC-SR04 initiator: trigger pulse, echo width measurement, timeout and hold-off.
// Define ULTRA_AUTO_TRIG_EN for free-running measurements (start is then ignored).
//
// state     | meaning
// IDLE      | waiting for start (or auto re-trigger)
// TRIG      | trig pin high, counting TRIG_CYCLES down
// WAIT_ECHO | waiting for a fresh echo rising edge, counting timeout down
// ECHO_HI   | echo high, counting width up (saturating)
// HOLDOFF   | quiet time before the next trigger, echo ignored
module ultrasonic_trigger_ctrl
  import ultrasonic_pkg::*;
#(
  parameter int TRIG_CYCLES    = TRIG_CYCLES_DEF,
  parameter int ECHO_TIMEOUT   = ECHO_TIMEOUT_DEF,
  parameter int HOLDOFF_CYCLES = HOLDOFF_CYCLES_DEF,
  parameter int CNT_W          = CNT_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  ultrasonic_trigger_ctrl_if.slave  bus
);

  localparam int CI_W = cnt_width(CNT_W, TRIG_CYCLES, ECHO_TIMEOUT, HOLDOFF_CYCLES);

  localparam logic [CI_W-1:0] TRIG_LD  = CI_W'(TRIG_CYCLES - 1);
  localparam logic [CI_W-1:0] WAIT_LD  = CI_W'(ECHO_TIMEOUT - 1);
  localparam logic [CI_W-1:0] HOLD_LD  = CI_W'(HOLDOFF_CYCLES - 1);
  localparam logic [CI_W-1:0] ECHO_MAX = CI_W'(ECHO_TIMEOUT);

  state_t          state;
  logic [CI_W-1:0] cnt;
  logic            echo_rise;
  logic            echo_fall;
  logic            go;

  echo_sync u_echo_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (bus.echo),
    .rise (echo_rise),
    .fall (echo_fall)
  );

`ifdef ULTRA_AUTO_TRIG_EN
  assign go = 1'b1;
`else
  assign go = bus.start;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      bus.trig       <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.timeout    <= 1'b0;
      bus.echo_width <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            state    <= TRIG;
            cnt      <= TRIG_LD;
            bus.trig <= 1'b1;
            bus.busy <= 1'b1;
          end
        end
        TRIG: begin
          if (cnt == '0) begin
            state    <= WAIT_ECHO;
            cnt      <= WAIT_LD;
            bus.trig <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WAIT_ECHO: begin
          // A rise seen on the last allowed cycle still counts as an echo.
          if (echo_rise) begin
            state <= ECHO_HI;
            cnt   <= CI_W'(1);
          end else if (cnt == '0) begin
            state       <= HOLDOFF;
            cnt         <= HOLD_LD;
            bus.timeout <= 1'b1;
            bus.done    <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ECHO_HI: begin
          if (echo_fall) begin
            state          <= HOLDOFF;
            cnt            <= HOLD_LD;
            bus.echo_width <= cnt[CNT_W-1:0];
            bus.timeout    <= 1'b0;
            bus.done       <= 1'b1;
          end else if (cnt >= ECHO_MAX) begin
            state       <= HOLDOFF;
            cnt         <= HOLD_LD;
            bus.timeout <= 1'b1;
            bus.done    <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLDOFF: begin
          if (cnt == '0) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          cnt      <= '0;
          bus.trig <= 1'b0;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ultrasonic_trigger_ctrl.sv
// Bench for ultrasonic_trigger_ctrl: planned directed + random stimulus against an event-time model.
module tb_ultrasonic_trigger_ctrl;
  import ultrasonic_pkg::*;

  localparam int TRIG = 5;
  localparam int TO   = 100;
  localparam int HOLD = 20;
  localparam int W    = 8;
  localparam int N    = 4000;
  localparam int NP   = N + 512;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ultrasonic_trigger_ctrl_if #(.CNT_W(W)) bus ();

  ultrasonic_trigger_ctrl #(
    .TRIG_CYCLES    (TRIG),
    .ECHO_TIMEOUT   (TO),
    .HOLDOFF_CYCLES (HOLD),
    .CNT_W          (W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // in[n] is driven during cycle n and sampled by edge n+1; out[n] is seen after edge n.
  bit start_plan [NP];
  bit echo_plan  [NP];
  bit exp_trig   [NP];
  bit exp_busy   [NP];
  bit exp_done   [NP];
  bit exp_to     [NP];
  int exp_w      [NP];
  bit ev         [NP];
  bit ev_to      [NP];
  int ev_w       [NP];

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input int n, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s @%0d: got %0d expected %0d", name, n, act, exp);
    end
  endtask

  function automatic bit ein(input int i);
    return (i < 0) ? 1'b0 : echo_plan[i];
  endfunction

  // The controller reacts at edge k to an echo change driven three cycles earlier.
  function automatic bit rise_at(input int k);
    return ein(k - 3) && !ein(k - 4);
  endfunction

  function automatic bit fall_at(input int k);
    return !ein(k - 3) && ein(k - 4);
  endfunction

  function automatic bit start_seen(input int m);
`ifdef ULTRA_AUTO_TRIG_EN
    return (m >= 1);
`else
    return start_plan[m-1];
`endif
  endfunction

  task automatic build_plan();
    int i, len;
    bit lvl;
    start_plan[2] = 1'b1;
    for (int k = 20; k <= 59; k++) echo_plan[k] = 1'b1;
    start_plan[90]  = 1'b1;
    start_plan[220] = 1'b1;
    start_plan[224] = 1'b1;
    for (int k = 230; k <= 339; k++) echo_plan[k] = 1'b1;
    start_plan[250] = 1'b1;
    start_plan[340] = 1'b1;
    start_plan[400] = 1'b1;
    for (int k = 415; k <= 424; k++) echo_plan[k] = 1'b1;
    i = 460;
    lvl = 1'b0;
    while (i < N - 300) begin
      len = lvl ? $urandom_range(1, 130) : $urandom_range(1, 160);
      for (int k = 0; k < len && i < N - 300; k++) begin
        echo_plan[i]  = lvl;
        start_plan[i] = ($urandom_range(0, 24) == 0);
        i++;
      end
      lvl = !lvl;
    end
  endtask

  task automatic build_model();
    int m, s, e, r, f, d, cur_w;
    bit cur_to;
    m = 1;
    while (m <= N) begin
      if (start_seen(m)) begin
        s = m;
        e = s + TRIG;
        for (int k = s; k < e; k++) exp_trig[k] = 1'b1;
        r = -1;
        for (int k = e + 1; k <= e + TO; k++) begin
          if (rise_at(k)) begin r = k; break; end
        end
        f = -1;
        if (r >= 0) begin
          for (int k = r + 1; k <= r + TO; k++) begin
            if (fall_at(k)) begin f = k; break; end
          end
        end
        if (r < 0) begin
          d = e + TO;
          ev_to[d] = 1'b1;
        end else if (f < 0) begin
          d = r + TO;
          ev_to[d] = 1'b1;
        end else begin
          d = f;
          ev_to[d] = 1'b0;
          ev_w[d] = f - r;
        end
        ev[d] = 1'b1;
        exp_done[d] = 1'b1;
        for (int k = s; k < d + HOLD; k++) exp_busy[k] = 1'b1;
        m = d + HOLD + 1;
      end else begin
        m++;
      end
    end
    cur_to = 1'b0;
    cur_w  = 0;
    for (int n = 0; n < NP; n++) begin
      if (ev[n]) begin
        cur_to = ev_to[n];
        if (!ev_to[n]) cur_w = ev_w[n];
      end
      exp_to[n] = cur_to;
      exp_w[n]  = cur_w;
    end
  endtask

  task automatic compare_cycle(input int n);
    check("trig",       n, 32'(bus.trig),       32'(exp_trig[n]));
    check("busy",       n, 32'(bus.busy),       32'(exp_busy[n]));
    check("done",       n, 32'(bus.done),       32'(exp_done[n]));
    check("timeout",    n, 32'(bus.timeout),    32'(exp_to[n]));
    check("echo_width", n, 32'(bus.echo_width), 32'(exp_w[n]));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_trig"},  0, 32'(bus.trig),       32'd0);
    check({tag, "_busy"},  0, 32'(bus.busy),       32'd0);
    check({tag, "_done"},  0, 32'(bus.done),       32'd0);
    check({tag, "_to"},    0, 32'(bus.timeout),    32'd0);
    check({tag, "_width"}, 0, 32'(bus.echo_width), 32'd0);
  endtask

  task automatic run_meas(input int wid);
    bit got;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (8) @(negedge clk);
    bus.echo = 1'b1;
    repeat (wid) @(negedge clk);
    bus.echo = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (bus.done) got = 1'b1;
    end
    check("meas_done_seen", wid, 32'(got),            32'd1);
    check("meas_width",     wid, 32'(bus.echo_width), 32'(wid));
    check("meas_timeout",   wid, 32'(bus.timeout),    32'd0);
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (!bus.busy) got = 1'b1;
    end
    check("meas_idle_again", wid, 32'(got), 32'd1);
  endtask

  initial begin
    int dones;
    bus.start = 1'b0;
    bus.echo  = 1'b0;
    build_plan();
    build_model();

`ifndef ULTRA_AUTO_TRIG_EN
    check("pin_trig_before", 2,   32'(exp_trig[2]),   32'd0);
    check("pin_trig_first",  3,   32'(exp_trig[3]),   32'd1);
    check("pin_trig_last",   7,   32'(exp_trig[7]),   32'd1);
    check("pin_trig_after",  8,   32'(exp_trig[8]),   32'd0);
    check("pin_done_echo40", 63,  32'(exp_done[63]),  32'd1);
    check("pin_width_40",    63,  32'(exp_w[63]),     32'd40);
    check("pin_to_valid",    63,  32'(exp_to[63]),    32'd0);
    check("pin_done_noecho", 196, 32'(exp_done[196]), 32'd1);
    check("pin_to_noecho",   196, 32'(exp_to[196]),   32'd1);
    check("pin_width_kept",  196, 32'(exp_w[196]),    32'd40);
    check("pin_done_long",   333, 32'(exp_done[333]), 32'd1);
    check("pin_to_long",     333, 32'(exp_to[333]),   32'd1);
    check("pin_idle_pre4",   400, 32'(exp_busy[400]), 32'd0);
    check("pin_trig4",       401, 32'(exp_trig[401]), 32'd1);
    check("pin_width_10",    428, 32'(exp_w[428]),    32'd10);
    check("pin_busy_end",    447, 32'(exp_busy[447]), 32'd1);
    check("pin_busy_off",    448, 32'(exp_busy[448]), 32'd0);
`endif

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    bus.start = start_plan[0];
    bus.echo  = echo_plan[0];
    compare_cycle(0);
    dones = 0;
    for (int n = 1; n <= N; n++) begin
      @(negedge clk);
      compare_cycle(n);
      if (n <= 455 && bus.done) dones++;
      bus.start = start_plan[n];
      bus.echo  = echo_plan[n];
    end

`ifndef ULTRA_AUTO_TRIG_EN
    check("directed_done_count", 455, 32'(dones), 32'd4);

    run_meas(7);
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk);
    check("pre_rst_trig", 0, 32'(bus.trig), 32'd1);
    #2 rst = 1'b1;
    #1 check_all_zero("rst_mid_trig");
    @(negedge clk); rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("post_rst1_busy", 0, 32'(bus.busy), 32'd0);
      check("post_rst1_trig", 0, 32'(bus.trig), 32'd0);
    end

    run_meas(7);
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (8) @(negedge clk);
    bus.echo = 1'b1;
    repeat (6) @(negedge clk);
    check("pre_rst_echo_busy", 0, 32'(bus.busy), 32'd1);
    check("pre_rst_echo_trig", 0, 32'(bus.trig), 32'd0);
    #2 rst = 1'b1;
    #1 check_all_zero("rst_mid_echo");
    @(negedge clk);
    rst = 1'b0;
    bus.echo = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("post_rst2_busy", 0, 32'(bus.busy), 32'd0);
      check("post_rst2_done", 0, 32'(bus.done), 32'd0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
